rom_dmem_loader: RTL
====================

# rom_dmem_loader

Boot-time loader and data-memory arbiter between the byte-wide constant ROM, the ARM core and `dmem`. After reset it streams `BYTE_COUNT` bytes from the ROM, packs them little-endian into 32-bit words and writes them into `dmem`, holding the core in reset. When the copy finishes, it passes `dmem` ownership to the core. It sits in `top` between `arm`, `ROM` and `dmem`; `cpu_hold` is OR-ed into the core's reset.

## Interface
Parameters:
- `ROM_AW`, 16: ROM address width.
- `ROM_BASE`, 0: first ROM byte address copied.
- `BYTE_COUNT`, 256: bytes copied. Must be a nonzero multiple of 4 and ≤ 2^ROM_AW; any other value is an elaboration error.
- `DMEM_BASE`, 0: byte address of the first `dmem` word written. Must be word-aligned.

Ports:
- `clk`  in  1: single clock; everything is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `reload`  in  1: one-cycle request to repeat the copy; honoured only in DONE.
- `rom_addr`  out  ROM_AW: byte address to the synchronous ROM.
- `rom_data`  in  8: ROM output, valid one cycle after the address is presented.
- `cpu_mem_write`  in  1: core write enable.
- `cpu_addr`  in  32: core data address.
- `cpu_wdata`  in  32: core write data.
- `dmem_we`  out  1: `dmem` write enable.
- `dmem_addr`  out  32: `dmem` byte address.
- `dmem_wdata`  out  32: `dmem` write data.
- `cpu_hold`  out  1: holds the core in reset while 1.
- `busy`  out  1: copy in progress.
- `done`  out  1: copy complete; core owns `dmem`.

## Operation
- States: LOAD, TAIL, LAST, DONE. The reset state is LOAD with read pointer `rp` = 0 and all lane/pending registers cleared.
- LOAD (cycles 0..N-1, N = BYTE_COUNT):
  - `rom_addr` = ROM_BASE + `rp`; `rp` increments every cycle.
  - On the cycle after `rp` = N-1 is issued, the state moves to TAIL.
- Capture: the byte for address k is latched at the end of cycle k+1 into lane k%4 of the pack register (lane 0 = bits 7:0).
- Write:
  - When lane 3 is latched, a write is pending for the next cycle.
  - That cycle drives `dmem_we`=1, `dmem_addr` = DMEM_BASE + 4·(k/4), `dmem_wdata` = the packed word.
  - Only one cycle of write per word.
- TAIL (cycle N): captures the final byte. LAST (cycle N+1): performs the final write. Then DONE.
- `rom_addr` holds its last issued value (ROM_BASE+N-1) in TAIL, LAST and DONE.
- Arbitration:
  - In LOAD, TAIL and LAST the loader owns `dmem`: outputs are the loader's, and `cpu_mem_write`, `cpu_addr` and `cpu_wdata` are ignored. When the loader has no pending write, `dmem_we`=0.
  - In DONE, `dmem_we`/`dmem_addr`/`dmem_wdata` are combinational copies of `cpu_mem_write`/`cpu_addr`/`cpu_wdata`.
- Status outputs:
  - `busy` = 1 in LOAD, TAIL and LAST. `done` = 1 in DONE only.
  - `cpu_hold` = ~`done`, and is 1 while `reset` is asserted.
- `reload`=1 in DONE moves to LOAD with `rp`=0 at the next edge. `cpu_hold` rises in that same edge's cycle. `reload` is ignored in every other state.

## Timing
- During reset (asynchronously):
  - `rom_addr` = ROM_BASE, `dmem_we`=0, `dmem_addr`=DMEM_BASE, `dmem_wdata`=0.
  - `cpu_hold`=1, `busy`=1, `done`=0.
- Cycle 0 is the first cycle after `reset` deasserts.
- Word j is written in cycle 4j+5. The last write is in cycle N+1; `done` rises in cycle N+2.
- Total core stall after reset release is N+2 cycles.
- Reset asserted mid-copy clears everything immediately. There is no partial write: `dmem_we` drops asynchronously. Release restarts the copy from cycle 0.
- `reload` and `reset` in the same cycle: reset wins.
- A core write request present in the cycle of the last loader write (LAST) is dropped. The core is held, so none is expected.

## Test plan
- N=8, ROM_BASE=0, DMEM_BASE=0x40, ROM bytes 0x11..0x88:
  - Cycle 5: `dmem_we`=1, addr 0x40, data 0x44332211.
  - Cycle 9: addr 0x44, data 0x88776655.
  - `dmem_we`=0 in every other cycle. `done`=1 and `cpu_hold`=0 from cycle 10.
- Hold `cpu_mem_write`=1, addr 0x0, data 0xDEADBEEF throughout the copy: `dmem_we` is high only in cycles 5 and 9. After `done`, the same inputs appear on the `dmem` outputs in the same cycle.
- Assert `reset` in cycle 3:
  - `dmem_we`=0, `rom_addr`=0 and `cpu_hold`=1 immediately.
  - After release, the first write (0x44332211) occurs 5 cycles later and `done` comes N+2 cycles after release.
- Pulse `reload` in DONE: `busy`=1 and `cpu_hold`=1 in the next cycle, and `rom_addr` restarts at ROM_BASE. Both writes repeat with identical values and offsets.
- Pulse `reload` during LOAD cycle 2: no effect; `done` still rises at cycle 10.
- N=4 at the minimum BYTE_COUNT: single write in cycle 5, `done` at cycle 6.

Source files
------------

// File: rtl/rom_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_dmem_loader
// Purpose  : Boot copy of a byte-wide ROM into 32-bit dmem, then hands dmem
//            ownership to the core (cpu_hold released).
// Revision : 1.0 - initial release
// ============================================================================
module rom_dmem_loader #(
    parameter int unsigned ROM_AW     = 16,
    parameter int unsigned ROM_BASE   = 0,
    parameter int unsigned BYTE_COUNT = 256,
    parameter int unsigned DMEM_BASE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam int unsigned RP_W = ROM_AW + 1;
    localparam logic [RP_W-1:0] C_LAST_RP = RP_W'(BYTE_COUNT - 1);

    if (BYTE_COUNT == 0 || (BYTE_COUNT % 4) != 0 ||
        64'(BYTE_COUNT) > (64'd1 << ROM_AW)) begin : g_bad_byte_count
        $error("rom_dmem_loader: BYTE_COUNT must be a nonzero multiple of 4 and <= 2**ROM_AW");
    end
    if ((DMEM_BASE % 4) != 0) begin : g_bad_dmem_base
        $error("rom_dmem_loader: DMEM_BASE must be word aligned");
    end

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_TAIL = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RP_W-1:0] rp_q, rp_d;
    logic [31:0]     pack_q, pack_d;
    logic            pend_q, pend_d;
    logic [31:0]     wr_addr_q, wr_addr_d;

    logic            w_cap;
    logic [RP_W-1:0] w_k;

    // The byte arriving this cycle belongs to the address issued last cycle.
    always_comb begin
        state_d   = state_q;
        rp_d      = rp_q;
        pack_d    = pack_q;
        pend_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        w_k       = rp_q - RP_W'(1);
        w_cap     = (state_q == S_LOAD && rp_q != '0) || (state_q == S_TAIL);

        case (state_q)
            S_LOAD: begin
                rp_d = rp_q + RP_W'(1);
                if (rp_q == C_LAST_RP) state_d = S_TAIL;
            end
            S_TAIL:  state_d = S_LAST;
            S_LAST:  state_d = S_DONE;
            S_DONE: begin
                if (reload) begin
                    state_d   = S_LOAD;
                    rp_d      = '0;
                    pack_d    = '0;
                    wr_addr_d = DMEM_BASE;
                end
            end
            default: state_d = S_LOAD;
        endcase

        if (w_cap) begin
            pack_d[{w_k[1:0], 3'b000} +: 8] = rom_data;
            if (w_k[1:0] == 2'd3) begin
                pend_d    = 1'b1;
                wr_addr_d = DMEM_BASE + 32'({w_k[RP_W-1:2], 2'b00});
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOAD;
            rp_q      <= '0;
            pack_q    <= '0;
            pend_q    <= 1'b0;
            wr_addr_q <= DMEM_BASE;
        end else begin
            state_q   <= state_d;
            rp_q      <= rp_d;
            pack_q    <= pack_d;
            pend_q    <= pend_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        rom_addr = ROM_AW'(ROM_BASE) +
                   ((state_q == S_LOAD) ? rp_q[ROM_AW-1:0] : C_LAST_RP[ROM_AW-1:0]);
        done     = (state_q == S_DONE);
        busy     = ~done;
        cpu_hold = ~done;
        if (done) begin
            dmem_we    = cpu_mem_write;
            dmem_addr  = cpu_addr;
            dmem_wdata = cpu_wdata;
        end else begin
            dmem_we    = pend_q;
            dmem_addr  = wr_addr_q;
            dmem_wdata = pack_q;
        end
    end

endmodule
`default_nettype wire
